// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and width helper for the debouncer bank
package debounce_pkg;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_STABLE_CNT  = 262143;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_COUNT_W     = 18;
  localparam int DEFAULT_LONG_W      = 26;
  localparam int DEFAULT_LONG_CNT    = 0;

  // Bits needed to hold value; avoids 2**W overflow when checking wide counters.
  function automatic int bits_for(input longint unsigned value);
    int n;
    n = 1;
    for (int i = 1; i < 64; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - raw input bank and debounced level/pulse outputs
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall,
    input  long_press
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall,
    output long_press
  );

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced channel: synchroniser, stability counter, edges, hold timer
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   COUNT_W     = DEFAULT_COUNT_W,
  parameter int   STABLE_CNT  = DEFAULT_STABLE_CNT,
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   LONG_W      = DEFAULT_LONG_W,
  parameter int   LONG_CNT    = DEFAULT_LONG_CNT,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_in,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_long_press
);

  localparam logic [COUNT_W-1:0]     STABLE_MAX = COUNT_W'(STABLE_CNT);
  localparam logic [SYNC_STAGES-1:0] SYNC_INIT  = {SYNC_STAGES{INIT_LEVEL}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_cand;
  logic [COUNT_W-1:0]     r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;

  logic w_s;
  logic w_commit;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_commit = (w_s == r_cand) && (r_cnt == STABLE_MAX) && (r_cand != r_out);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= SYNC_INIT;
      r_cand <= INIT_LEVEL;
      r_cnt  <= '0;
      r_out  <= INIT_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      // Any movement of the synchronised level restarts qualification.
      if (w_s != r_cand) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt < STABLE_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_out <= r_cand;
      end
      r_rise <= w_commit & r_cand;
      r_fall <= w_commit & ~r_cand;
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  if (LONG_CNT > 0) begin : g_long
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic [LONG_W-1:0] r_hcnt;
    logic              r_long;

    // hcnt is 0 in the rise cycle and counts while out stays high; the pulse
    // lands LONG_CNT cycles after rise, and is dropped if out falls that cycle.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
      end else begin
        if (!r_out) begin
          r_hcnt <= '0;
        end else if (r_hcnt < LONG_MAX) begin
          r_hcnt <= r_hcnt + 1'b1;
        end
        r_long <= r_out && !w_commit && (r_hcnt == LONG_LAST);
      end
    end

    assign o_long_press = r_long;
  end else begin : g_no_long
    assign o_long_press = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - bank of independent switch debouncers sharing one clock
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                 CHANNELS    = DEFAULT_CHANNELS,
  parameter int                 COUNT_W     = DEFAULT_COUNT_W,
  parameter int                 STABLE_CNT  = DEFAULT_STABLE_CNT,
  parameter int                 SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [CHANNELS-1:0] INIT_LEVEL = '0,
  parameter int                 LONG_W      = DEFAULT_LONG_W,
  parameter int                 LONG_CNT    = DEFAULT_LONG_CNT
) (
  input  logic            clock,
  input  logic            reset_n,
  debounce_multi_if.slave bus
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CNT < 1 || bits_for(longint'(STABLE_CNT)) > COUNT_W) begin : g_bad_stable
    $error("debounce_multi: STABLE_CNT must be >= 1 and fit in COUNT_W bits");
  end
  if (LONG_CNT < 0 || (LONG_CNT > 0 && bits_for(longint'(LONG_CNT)) > LONG_W)) begin : g_bad_long
    $error("debounce_multi: LONG_CNT must be >= 0 and fit in LONG_W bits");
  end

  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_long;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .COUNT_W     (COUNT_W),
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_W      (LONG_W),
      .LONG_CNT    (LONG_CNT),
      .INIT_LEVEL  (INIT_LEVEL[g])
    ) u_channel (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_in         (bus.in[g]),
      .o_out        (w_out[g]),
      .o_rise       (w_rise[g]),
      .o_fall       (w_fall[g]),
      .o_long_press (w_long[g])
    );
  end

  assign bus.out        = w_out;
  assign bus.rise       = w_rise;
  assign bus.fall       = w_fall;
  assign bus.long_press = w_long;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi (4 ch, STABLE_CNT=4, LONG_CNT=10)
module tb_debounce_multi;

  localparam int LAT = 8;
  localparam int LP  = 10;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int cyc;
    int id;
  } ev_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  ev_t  sb[$];

  debounce_multi_if #(.CHANNELS(4)) bus ();

  debounce_multi #(
    .CHANNELS    (4),
    .COUNT_W     (3),
    .STABLE_CNT  (4),
    .SYNC_STAGES (2),
    .INIT_LEVEL  (4'b0000),
    .LONG_W      (4),
    .LONG_CNT    (LP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int ch, input int kind, input int at);
    ev_t e;
    e.cyc = at;
    e.id  = ch * 4 + kind;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick(1);
    check("drain", sb.size(), 0);
    tick(3);
  endtask

  // Every pulse seen must be the next scheduled event, on its scheduled cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int ch = 0; ch < 4; ch++) begin
        check("rise_fall_excl", int'(bus.rise[ch] & bus.fall[ch]), 0);
        for (int k = 0; k < 3; k++) begin
          logic p;
          ev_t  e;
          p = (k == K_RISE) ? bus.rise[ch] : (k == K_FALL) ? bus.fall[ch] : bus.long_press[ch];
          if (p) begin
            if (sb.size() == 0) begin
              check("unexpected_pulse", ch * 4 + k, -1);
            end else begin
              e = sb.pop_front();
              check("pulse_id", ch * 4 + k, e.id);
              check("pulse_cyc", cyc, e.cyc);
            end
          end
        end
      end
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        ev_t m;
        m = sb.pop_front();
        check("missed_pulse_id", -1, m.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus.in   = 4'b0000;
    tick(3);
    check("rst_out", int'(bus.out), 0);
    check("rst_rise", int'(bus.rise), 0);
    check("rst_fall", int'(bus.fall), 0);
    check("rst_long", int'(bus.long_press), 0);
    reset_n = 1'b1;
    tick(2);

    // clean step on ch0, held: rise then one long press
    bus.in[0] = 1'b1;
    e = cyc;
    push(0, K_RISE, e + LAT);
    push(0, K_LONG, e + LAT + LP);
    tick(LAT - 1);
    check("s1_out_before", int'(bus.out), 0);
    tick(1);
    check("s1_out_after", int'(bus.out), 1);
    wait_idle();
    check("s1_out_settled", int'(bus.out), 4'b0001);

    // bounce on ch1, toggling every 3 cycles, then held high
    for (int k = 0; k < 8; k++) begin
      bus.in[1] = (k % 2 == 0);
      tick(3);
    end
    check("s2_out_bounce", int'(bus.out), 4'b0001);
    bus.in[1] = 1'b1;
    e = cyc;
    push(1, K_RISE, e + LAT);
    push(1, K_LONG, e + LAT + LP);
    wait_idle();
    check("s2_out_settled", int'(bus.out), 4'b0011);
    bus.in[1] = 1'b0;
    push(1, K_FALL, cyc + LAT);
    wait_idle();

    // glitches on ch2: 1 cycle and 4 cycles
    bus.in[2] = 1'b1;
    tick(1);
    bus.in[2] = 1'b0;
    tick(10);
    bus.in[2] = 1'b1;
    tick(4);
    bus.in[2] = 1'b0;
    tick(20);
    check("s3_out", int'(bus.out), 4'b0001);

    // simultaneous fall on ch0 and rise on ch3
    bus.in[0] = 1'b0;
    bus.in[3] = 1'b1;
    e = cyc;
    push(0, K_FALL, e + LAT);
    push(3, K_RISE, e + LAT);
    push(3, K_LONG, e + LAT + LP);
    wait_idle();
    check("s4_out", int'(bus.out), 4'b1000);
    bus.in[3] = 1'b0;
    push(3, K_FALL, cyc + LAT);
    wait_idle();

    // long hold: single long press, no repeat
    bus.in[0] = 1'b1;
    e = cyc;
    push(0, K_RISE, e + LAT);
    push(0, K_LONG, e + LAT + LP);
    wait_idle();
    tick(30);
    check("s5_out_held", int'(bus.out), 4'b0001);
    bus.in[0] = 1'b0;
    push(0, K_FALL, cyc + LAT);
    wait_idle();

    // short hold: out high 6 cycles, no long press
    bus.in[0] = 1'b1;
    e = cyc;
    push(0, K_RISE, e + LAT);
    tick(6);
    bus.in[0] = 1'b0;
    push(0, K_FALL, e + 6 + LAT);
    wait_idle();
    tick(15);
    check("s5_out_short", int'(bus.out), 0);

    // reset mid-count on ch1 while ch3 is high
    bus.in[3] = 1'b1;
    e = cyc;
    push(3, K_RISE, e + LAT);
    push(3, K_LONG, e + LAT + LP);
    wait_idle();
    check("s6_out_pre", int'(bus.out), 4'b1000);
    bus.in[1] = 1'b1;
    tick(5);
    reset_n = 1'b0;
    #1;
    check("s6_out_async", int'(bus.out), 0);
    check("s6_pulses_async", int'(bus.rise | bus.fall | bus.long_press), 0);
    tick(2);
    reset_n = 1'b1;
    e = cyc;
    push(1, K_RISE, e + LAT);
    push(3, K_RISE, e + LAT);
    push(1, K_LONG, e + LAT + LP);
    push(3, K_LONG, e + LAT + LP);
    tick(LAT - 1);
    check("s6_out_before", int'(bus.out), 0);
    tick(1);
    check("s6_out_after", int'(bus.out), 4'b1010);
    wait_idle();

    check("final_queue", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
